// File: rtl/calc_key_scheduler.sv
// calc_key_scheduler
// Merges key codes from the keypad front-end and the auto/script port into one
// paced stream for the calculator. Accepted codes go into a small FIFO and are
// issued as single-cycle key_valid pulses, with enough idle time between pulses
// for the keypad->ALU->encoder->display chain to settle. AC (code 10) flushes
// anything still queued and is accepted even when the FIFO is full.

module calc_key_scheduler #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYC    = 4,
   parameter int SETTLE_CYC = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     kp_req,
   input  logic [4:0]               kp_code,
   output logic                     kp_ack,
   input  logic                     au_req,
   input  logic [4:0]               au_code,
   output logic                     au_ack,
   output logic [4:0]               key_code,
   output logic                     key_valid,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [4:0] CODE_AC    = 5'd10;
   localparam logic [4:0] CODE_NOP   = 5'd11;
   localparam logic [4:0] CODE_EQ    = 5'd17;
   localparam logic [4:0] CODE_LIMIT = 5'd18;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [4:0]      fifo_mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            last_kp;

   logic            fifo_full;
   logic            kp_elig;
   logic            au_elig;
   logic            grant_kp;
   logic            grant_au;
   logic            grant;
   logic [4:0]      grant_code;
   logic            do_flush;
   logic            do_push;
   logic            do_pop;

   // Decide this cycle's single grant and what it does to the FIFO; a source
   // whose ack is still high is excluded so one request yields one code.
   always_comb begin
      fifo_full  = (fifo_cnt == CW'(DEPTH));
      kp_elig    = kp_req & ~kp_ack & (~fifo_full | (kp_code == CODE_AC));
      au_elig    = au_req & ~au_ack & (~fifo_full | (au_code == CODE_AC));
      grant_kp   = kp_elig & (~au_elig | ~last_kp);
      grant_au   = au_elig & ~grant_kp;
      grant      = grant_kp | grant_au;
      grant_code = grant_kp ? kp_code : au_code;
      do_flush   = grant & (grant_code == CODE_AC);
      do_push    = grant & (grant_code != CODE_AC) & (grant_code != CODE_NOP) &
                   (grant_code < CODE_LIMIT);
      do_pop     = (state == ST_IDLE) & (fifo_cnt != '0);
   end

   // Register the acks and remember which source won last for round-robin ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kp_ack  <= 1'b0;
         au_ack  <= 1'b0;
         last_kp <= 1'b0;
      end else begin
         kp_ack <= grant_kp;
         au_ack <= grant_au;
         if (grant) begin
            last_kp <= grant_kp;
         end
      end
   end

   // FIFO storage; an AC always lands in slot 0 because the flush rewinds both pointers.
   always_ff @(posedge clk) begin
      if (do_flush) begin
         fifo_mem[0] <= CODE_AC;
      end else if (do_push) begin
         fifo_mem[wr_ptr] <= grant_code;
      end
   end

   // FIFO pointers and occupancy; a flush overrides any simultaneous pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (do_flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= AW'(1);
         fifo_cnt <= CW'(1);
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_cnt <= fifo_cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Issue/pacing FSM: pop into key_code with a one-cycle valid, then hold off
   // for the gap or the longer settle time after '='.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         busy      <= (fifo_cnt != '0) | (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (fifo_cnt != '0) begin
                  key_code  <= fifo_mem[rd_ptr];
                  key_valid <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer <= (key_code == CODE_EQ) ? TW'(SETTLE_CYC) : TW'(GAP_CYC);
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (timer <= TW'(1)) begin
                  timer <= '0;
                  state <= ST_IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_key_scheduler.sv
// Testbench for calc_key_scheduler: a queue-based reference model checks every
// output on every cycle, while directed scenarios pin hand-derived timings and
// orders; a randomized phase runs both sources against the model.

module tb_calc_key_scheduler;

   localparam int DEPTH  = 4;
   localparam int GAP    = 4;
   localparam int SETTLE = 8;

   logic       clk;
   logic       rst;
   logic       kp_req;
   logic [4:0] kp_code;
   logic       kp_ack;
   logic       au_req;
   logic [4:0] au_code;
   logic       au_ack;
   logic [4:0] key_code;
   logic       key_valid;
   logic       busy;
   logic [2:0] fifo_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   int         mq[$];
   bit         m_kp_ack;
   bit         m_au_ack;
   bit         m_valid;
   bit         m_busy;
   bit         m_last_kp;
   int         m_code;
   int         m_cool;

   // observation logs used by the directed checks
   int pulse_cyc[$];
   int pulse_code[$];
   int grant_src[$];
   int grant_cyc[$];
   int busy_fall_cyc;
   int last_au_grant;
   bit prev_busy;

   calc_key_scheduler #(
      .DEPTH(DEPTH),
      .GAP_CYC(GAP),
      .SETTLE_CYC(SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp_req(kp_req),
      .kp_code(kp_code),
      .kp_ack(kp_ack),
      .au_req(au_req),
      .au_code(au_code),
      .au_ack(au_ack),
      .key_code(key_code),
      .key_valid(key_valid),
      .busy(busy),
      .fifo_cnt(fifo_cnt)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle index, advanced on each rising edge
   always @(posedge clk) cyc++;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_list(input string name, input int act[$], input int exp[$]);
      check_output({name, "_len"}, act.size(), exp.size());
      for (int i = 0; i < exp.size() && i < act.size(); i++) begin
         check_output($sformatf("%s_%0d", name, i), act[i], exp[i]);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_kp_ack  = 0;
      m_au_ack  = 0;
      m_valid   = 0;
      m_busy    = 0;
      m_last_kp = 0;
      m_code    = 0;
      m_cool    = 0;
   endtask

   // One clock of the reference: inputs are those stable in the current cycle,
   // the model afterwards describes what the DUT shows in the next cycle.
   task automatic model_step();
      bit e_kp, e_au, g_kp, g_au, n_busy, n_valid;
      int c;
      e_kp   = kp_req && !m_kp_ack && (mq.size() < DEPTH || kp_code == 5'd10);
      e_au   = au_req && !m_au_ack && (mq.size() < DEPTH || au_code == 5'd10);
      g_kp   = e_kp && (!e_au || !m_last_kp);
      g_au   = e_au && !g_kp;
      n_busy = (mq.size() != 0) || (m_cool > 0);
      n_valid = 0;
      if (m_cool == 0 && mq.size() > 0) begin
         n_valid = 1;
         m_code  = mq.pop_front();
         m_cool  = ((m_code == 17) ? SETTLE : GAP) + 1;
      end else if (m_cool > 0) begin
         m_cool--;
      end
      if (g_kp || g_au) begin
         c = g_kp ? int'(kp_code) : int'(au_code);
         if (c == 10) begin
            mq.delete();
            mq.push_back(10);
         end else if (c != 11 && c < 18) begin
            mq.push_back(c);
         end
         m_last_kp = g_kp;
      end
      m_kp_ack = g_kp;
      m_au_ack = g_au;
      m_valid  = n_valid;
      m_busy   = n_busy;
   endtask

   // Compare the DUT against the model every cycle, log events, then advance the model.
   always @(negedge clk) begin
      if (!rst) model_reset();
      check_output("kp_ack",    int'(kp_ack),    int'(m_kp_ack));
      check_output("au_ack",    int'(au_ack),    int'(m_au_ack));
      check_output("key_valid", int'(key_valid), int'(m_valid));
      check_output("key_code",  int'(key_code),  m_code);
      check_output("busy",      int'(busy),      int'(m_busy));
      check_output("fifo_cnt",  int'(fifo_cnt),  mq.size());
      if (key_valid) begin
         pulse_cyc.push_back(cyc);
         pulse_code.push_back(int'(key_code));
      end
      if (kp_ack) begin
         grant_src.push_back(0);
         grant_cyc.push_back(cyc - 1);
      end
      if (au_ack) begin
         grant_src.push_back(1);
         grant_cyc.push_back(cyc - 1);
         last_au_grant = cyc - 1;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (rst) model_step();
   end

   task automatic clear_logs();
      pulse_cyc.delete();
      pulse_code.delete();
      grant_src.delete();
      grant_cyc.delete();
      busy_fall_cyc = -1;
      last_au_grant = -1;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst    = 1'b0;
      kp_req = 1'b0;
      au_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      clear_logs();
   endtask

   // Raise a request on source src (0 keypad, 1 auto) and hold it until acked.
   task automatic apply_stimulus(input int src, input logic [4:0] c);
      bit got;
      @(posedge clk); #1;
      if (src == 0) begin kp_req = 1'b1; kp_code = c; end
      else          begin au_req = 1'b1; au_code = c; end
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk); #1;
         if ((src == 0 && kp_ack) || (src == 1 && au_ack)) got = 1;
      end
      if (src == 0) kp_req = 1'b0;
      else          au_req = 1'b0;
      check_output(src == 0 ? "kp_ack_timeout" : "au_ack_timeout", int'(got), 1);
   endtask

   function automatic logic [4:0] rand_code();
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      return 5'($urandom_range(0, 9));
      else if (r < 70) return 5'($urandom_range(12, 17));
      else if (r < 78) return 5'd17;
      else if (r < 84) return 5'd10;
      else if (r < 90) return 5'd11;
      else             return 5'($urandom_range(18, 31));
   endfunction

   task automatic random_source(input int src, input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         apply_stimulus(src, rand_code());
      end
   endtask

   initial begin
      int e[$];
      rst     = 1'b1;
      kp_req  = 1'b0;
      au_req  = 1'b0;
      kp_code = '0;
      au_code = '0;
      prev_busy = 1'b0;
      clear_logs();
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      clear_logs();

      // single key: one ack, pulse two cycles after the grant
      apply_stimulus(0, 5'd3);
      repeat (8) @(posedge clk);
      e = {3};
      check_list("t1_codes", pulse_code, e);
      e = {0};
      check_list("t1_grants", grant_src, e);
      if (pulse_cyc.size() > 0 && grant_cyc.size() > 0)
         check_output("t1_latency", pulse_cyc[0] - grant_cyc[0], 2);

      // burst: order kept, 6-cycle spacing, busy falls 10 cycles after '='
      clear_logs();
      apply_stimulus(0, 5'd1);
      apply_stimulus(0, 5'd2);
      apply_stimulus(0, 5'd16);
      apply_stimulus(0, 5'd5);
      apply_stimulus(0, 5'd17);
      repeat (40) @(posedge clk);
      e = {1, 2, 16, 5, 17};
      check_list("t2_codes", pulse_code, e);
      for (int i = 0; i + 1 < pulse_cyc.size(); i++)
         check_output($sformatf("t2_spacing_%0d", i), pulse_cyc[i+1] - pulse_cyc[i], 6);
      if (pulse_cyc.size() == 5)
         check_output("t2_busy_fall", busy_fall_cyc - pulse_cyc[4], 10);

      // simultaneous requests alternate starting with the keypad
      apply_reset();
      repeat (3) begin
         fork
            apply_stimulus(0, 5'd7);
            apply_stimulus(1, 5'd9);
         join
      end
      repeat (60) @(posedge clk);
      e = {0, 1, 0, 1, 0, 1};
      check_list("t3_grants", grant_src, e);
      e = {7, 9, 7, 9, 7, 9};
      check_list("t3_codes", pulse_code, e);

      // full FIFO with the settle timer running holds off the auto source
      apply_reset();
      apply_stimulus(0, 5'd17);
      apply_stimulus(0, 5'd2);
      apply_stimulus(0, 5'd3);
      apply_stimulus(0, 5'd4);
      apply_stimulus(0, 5'd5);
      fork
         apply_stimulus(1, 5'd8);
         begin
            repeat (3) begin
               @(negedge clk);
               check_output("t4_full_cnt", int'(fifo_cnt), 4);
               check_output("t4_no_ack", int'(au_ack), 0);
            end
         end
      join
      repeat (60) @(posedge clk);
      e = {17, 2, 3, 4, 5, 8};
      check_list("t4_codes", pulse_code, e);
      if (pulse_cyc.size() > 1)
         check_output("t4_au_grant_at_pop", last_au_grant - pulse_cyc[1], 0);

      // AC flushes queued 1,2,3 and is the only thing issued afterwards
      apply_reset();
      apply_stimulus(0, 5'd17);
      apply_stimulus(0, 5'd1);
      apply_stimulus(0, 5'd2);
      apply_stimulus(0, 5'd3);
      apply_stimulus(0, 5'd10);
      @(negedge clk);
      check_output("t5_cnt_after_ac", int'(fifo_cnt), 1);
      repeat (30) @(posedge clk);
      e = {17, 10};
      check_list("t5_codes", pulse_code, e);

      // reset during WAIT with two entries queued
      apply_reset();
      apply_stimulus(0, 5'd17);
      apply_stimulus(0, 5'd1);
      apply_stimulus(0, 5'd2);
      @(negedge clk);
      check_output("t6_cnt_before", int'(fifo_cnt), 2);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("t6_valid", int'(key_valid), 0);
      check_output("t6_busy", int'(busy), 0);
      check_output("t6_cnt", int'(fifo_cnt), 0);
      check_output("t6_code", int'(key_code), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      clear_logs();
      repeat (20) @(posedge clk);
      check_output("t6_no_pulse", pulse_code.size(), 0);

      // randomized traffic from both sources, checked by the model every cycle
      apply_reset();
      fork
         random_source(0, 150);
         random_source(1, 150);
      join
      repeat (40) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
